// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register file.
package i2c_target_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_PTR,
        WR_DATA,
        RD_DATA,
        IGNORE
    } state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_pin_sync.sv
// Two-flop synchronizer for an asynchronous bus pin, plus edge detection
// on the synchronized level. Resets to the idle-high bus level.
module i2c_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_p0;
    logic sync_p1;
    logic last_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            last_p2 <= 1'b1;
        end else begin
            meta_p0 <= pin;
            // stage p0 -> p1: second synchronizer flop
            sync_p1 <= meta_p0;
            // stage p1 -> p2: previous value for edge detection
            last_p2 <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign rise  = sync_p1 & ~last_p2;
    assign fall  = ~sync_p1 & last_p2;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-addressable register file and an auto-incrementing
// pointer. Acknowledges only SLAVE_ADDR; START/STOP always resynchronize it.
module i2c_target_regfile
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h44,
    parameter int         NUM_REGS   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda_i,
    output logic sda_o
);

    localparam int PTR_W = $clog2(NUM_REGS);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS_PER_BYTE - 1);
    localparam logic [CNT_W-1:0] CNT_ACK  = CNT_W'(BITS_PER_BYTE);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(BITS_PER_BYTE + 1);
    localparam logic SDA_REL = 1'b1;

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_pin_sync u_scl_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (scl),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_pin_sync u_sda_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (sda_i),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    logic start_evt, stop_evt;
    assign start_evt = sda_fall & scl_lvl;
    assign stop_evt  = sda_rise & scl_lvl;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               bit_cnt_q, bit_cnt_d;
    logic [BITS_PER_BYTE-1:0]       shift_q, shift_d;
    logic [PTR_W-1:0]               ptr_q, ptr_d;
    logic                           sda_o_q, sda_o_d;
    logic                           wr_en;
    logic [BITS_PER_BYTE-1:0]       regs [NUM_REGS];

    logic [BITS_PER_BYTE-1:0]       shift_in;
    logic [BITS_PER_BYTE-1:0]       rd_byte;
    logic [2:0]                     rd_idx;

    assign shift_in = {shift_q[BITS_PER_BYTE-2:0], sda_lvl};
    assign rd_byte  = regs[ptr_q];
    // read data stays parallel in shift_q; the bit counter picks the bit
    assign rd_idx   = 3'(BITS_PER_BYTE - 1) - bit_cnt_q[2:0];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_o_d   = sda_o_q;
        wr_en     = 1'b0;

        if (start_evt) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            shift_d   = '0;
            sda_o_d   = SDA_REL;
        end else if (stop_evt) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_o_d   = SDA_REL;
        end else if (scl_rise) begin
            case (state_q)
                ADDR, WR_PTR, WR_DATA: begin
                    if (bit_cnt_q < CNT_ACK) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else begin
                        bit_cnt_d = CNT_END;
                    end
                    if (bit_cnt_q == CNT_LAST) begin
                        if (state_q == ADDR) begin
                            state_d = (shift_in[BITS_PER_BYTE-1:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
                        end else if (state_q == WR_PTR) begin
                            ptr_d = shift_in[PTR_W-1:0];
                        end else begin
                            wr_en = 1'b1;
                            ptr_d = ptr_q + PTR_W'(1);
                        end
                    end
                end
                ADDR_ACK: bit_cnt_d = CNT_END;
                RD_DATA: begin
                    if (bit_cnt_q < CNT_ACK) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (sda_lvl == ACK) begin
                        bit_cnt_d = CNT_END;
                        ptr_d     = ptr_q + PTR_W'(1);
                    end else begin
                        state_d   = IGNORE;
                        bit_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                ADDR_ACK, WR_PTR, WR_DATA: begin
                    if (bit_cnt_q == CNT_ACK) begin
                        sda_o_d = ACK;
                    end else if (bit_cnt_q == CNT_END) begin
                        sda_o_d   = SDA_REL;
                        bit_cnt_d = '0;
                        if (state_q == ADDR_ACK) begin
                            if (shift_q[0]) begin
                                state_d = RD_DATA;
                                shift_d = rd_byte;
                                sda_o_d = rd_byte[BITS_PER_BYTE-1];
                            end else begin
                                state_d = WR_PTR;
                            end
                        end else if (state_q == WR_PTR) begin
                            state_d = WR_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    if (bit_cnt_q == CNT_END) begin
                        shift_d   = rd_byte;
                        sda_o_d   = rd_byte[BITS_PER_BYTE-1];
                        bit_cnt_d = '0;
                    end else if (bit_cnt_q == CNT_ACK) begin
                        sda_o_d = SDA_REL;
                    end else if (bit_cnt_q != '0) begin
                        sda_o_d = shift_q[rd_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            sda_o_q   <= SDA_REL;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_o_q   <= sda_o_d;
            if (wr_en) begin
                regs[ptr_q] <= shift_in;
            end
        end
    end

    assign sda_o = sda_o_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench: a bit-banged I2C master drives the target and checks ACKs,
// read data, pointer and register contents against hand-computed values.
module tb_i2c_target_regfile;
    import i2c_target_pkg::*;

    localparam int PH   = 8;
    localparam int HOLD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic sda_m = 1'b1;
    logic sda_o;
    logic sda_bus;

    int n_cmp = 0;
    int n_err = 0;

    assign sda_bus = sda_m & sda_o;

    always #5 clk = ~clk;

    i2c_target_regfile #(
        .SLAVE_ADDR (7'h44),
        .NUM_REGS   (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .scl   (scl),
        .sda_i (sda_bus),
        .sda_o (sda_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ph();
        repeat (PH) @(negedge clk);
    endtask

    task automatic bus_start();
        repeat (HOLD) @(negedge clk);
        sda_m = 1'b1;
        wait_ph();
        scl = 1'b1;
        wait_ph();
        sda_m = 1'b0;
        wait_ph();
        scl = 1'b0;
    endtask

    task automatic bus_stop();
        repeat (HOLD) @(negedge clk);
        sda_m = 1'b0;
        wait_ph();
        scl = 1'b1;
        wait_ph();
        sda_m = 1'b1;
        wait_ph();
    endtask

    task automatic clock_bit(input logic b, output logic seen);
        repeat (HOLD) @(negedge clk);
        sda_m = b;
        wait_ph();
        scl = 1'b1;
        repeat (PH / 2) @(negedge clk);
        seen = sda_bus;
        repeat (PH / 2) @(negedge clk);
        scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        logic dummy;
        logic ack;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], dummy);
        clock_bit(1'b1, ack);
        check_eq(tag, 32'(ack), 32'(exp_ack));
    endtask

    task automatic read_byte(input logic mack, input logic [7:0] exp, input string tag);
        logic [7:0] d;
        logic dummy;
        for (int i = 7; i >= 0; i--) clock_bit(1'b1, d[i]);
        clock_bit(mack, dummy);
        check_eq(tag, 32'(d), 32'(exp));
    endtask

    initial begin
        logic dummy;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_sda_o", 32'(sda_o), 32'h1);
        check_eq("rst_state", 32'(dut.state_q), 32'(IDLE));
        check_eq("rst_ptr", 32'(dut.ptr_q), 32'h0);
        check_eq("rst_reg3", 32'(dut.regs[3]), 32'h0);

        // wrong address: no ACK, nothing written
        bus_start();
        write_byte(8'hA0, 1'b1, "nack_addr");
        check_eq("nack_state", 32'(dut.state_q), 32'(IGNORE));
        bus_stop();
        check_eq("nack_idle", 32'(dut.state_q), 32'(IDLE));
        check_eq("nack_reg0", 32'(dut.regs[0]), 32'h0);
        check_eq("nack_ptr", 32'(dut.ptr_q), 32'h0);

        // recovery: pointer 3, two data bytes
        bus_start();
        write_byte(8'h88, 1'b0, "wr_addr_ack");
        write_byte(8'h03, 1'b0, "wr_ptr_ack");
        write_byte(8'hA5, 1'b0, "wr_d0_ack");
        write_byte(8'h5A, 1'b0, "wr_d1_ack");
        bus_stop();
        check_eq("wr_reg3", 32'(dut.regs[3]), 32'hA5);
        check_eq("wr_reg4", 32'(dut.regs[4]), 32'h5A);
        check_eq("wr_ptr", 32'(dut.ptr_q), 32'h5);

        // repeated-START read of two bytes, ACK then NACK
        bus_start();
        write_byte(8'h88, 1'b0, "rd_waddr_ack");
        write_byte(8'h03, 1'b0, "rd_ptr_ack");
        bus_start();
        write_byte(8'h89, 1'b0, "rd_raddr_ack");
        read_byte(1'b0, 8'hA5, "rd_byte0");
        read_byte(1'b1, 8'h5A, "rd_byte1");
        check_eq("rd_nack_sda_o", 32'(sda_o), 32'h1);
        check_eq("rd_nack_state", 32'(dut.state_q), 32'(IGNORE));
        bus_stop();
        check_eq("rd_ptr", 32'(dut.ptr_q), 32'h4);

        // pointer wrap on write
        bus_start();
        write_byte(8'h88, 1'b0, "wrap_addr_ack");
        write_byte(8'h0F, 1'b0, "wrap_ptr_ack");
        write_byte(8'h11, 1'b0, "wrap_d0_ack");
        write_byte(8'h22, 1'b0, "wrap_d1_ack");
        bus_stop();
        check_eq("wrap_reg15", 32'(dut.regs[15]), 32'h11);
        check_eq("wrap_reg0", 32'(dut.regs[0]), 32'h22);
        check_eq("wrap_ptr", 32'(dut.ptr_q), 32'h1);

        // pointer byte upper bits ignored, wrap on read
        bus_start();
        write_byte(8'h88, 1'b0, "wrapr_addr_ack");
        write_byte(8'hFF, 1'b0, "wrapr_ptr_ack");
        bus_start();
        write_byte(8'h89, 1'b0, "wrapr_raddr_ack");
        read_byte(1'b0, 8'h11, "wrapr_byte0");
        read_byte(1'b1, 8'h22, "wrapr_byte1");
        bus_stop();
        check_eq("wrapr_ptr", 32'(dut.ptr_q), 32'h0);

        // STOP after four address bits, then a normal transaction
        bus_start();
        clock_bit(1'b1, dummy);
        clock_bit(1'b0, dummy);
        clock_bit(1'b0, dummy);
        clock_bit(1'b0, dummy);
        bus_stop();
        check_eq("mid_stop_state", 32'(dut.state_q), 32'(IDLE));
        check_eq("mid_stop_sda_o", 32'(sda_o), 32'h1);
        bus_start();
        write_byte(8'h88, 1'b0, "mid_addr_ack");
        write_byte(8'h07, 1'b0, "mid_ptr_ack");
        bus_stop();
        check_eq("mid_ptr", 32'(dut.ptr_q), 32'h7);

        // reset while target drives a 0 data bit (0xA5 bit 6)
        bus_start();
        write_byte(8'h88, 1'b0, "rst_waddr_ack");
        write_byte(8'h03, 1'b0, "rst_ptr_ack");
        bus_start();
        write_byte(8'h89, 1'b0, "rst_raddr_ack");
        clock_bit(1'b1, dummy);
        check_eq("rst_rd_bit7", 32'(dummy), 32'h1);
        wait_ph();
        check_eq("rst_pre_sda_o", 32'(sda_o), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid_sda_o", 32'(sda_o), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
        check_eq("rst_mid_ptr", 32'(dut.ptr_q), 32'h0);
        check_eq("rst_mid_reg3", 32'(dut.regs[3]), 32'h0);
        check_eq("rst_mid_reg4", 32'(dut.regs[4]), 32'h0);
        check_eq("rst_mid_reg15", 32'(dut.regs[15]), 32'h0);
        sda_m = 1'b1;
        wait_ph();
        scl = 1'b1;
        wait_ph();
        check_eq("rst_stay_idle", 32'(dut.state_q), 32'(IDLE));
        bus_start();
        write_byte(8'h89, 1'b0, "rst_rd_addr_ack");
        read_byte(1'b1, 8'h00, "rst_rd_byte");
        bus_stop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
